// File: rtl/cordic_phase_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_phase_gen_pkg
// Description : Shared constants and types for the CORDIC phase generator
//               and the pipelined rotation-mode CORDIC it feeds.
//               Angle word: 2^ANGLE_WIDTH = 360 deg, top two bits = quadrant.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_phase_gen_pkg;

    localparam int ANGLE_WIDTH = 32;
    localparam int XY_WIDTH    = 16;
    localparam int STAGES      = 16;

    // round(32767 * 0.6072529): pre-divides by the CORDIC gain so the
    // rotated vector comes out at full scale.
    localparam logic [XY_WIDTH-1:0] GAIN_X = 16'd19898;

    // Quadrant boundaries: 0, pi/2, pi, 3pi/2
    localparam logic [ANGLE_WIDTH-1:0] QUAD_0 = 32'h0000_0000;
    localparam logic [ANGLE_WIDTH-1:0] QUAD_1 = 32'h4000_0000;
    localparam logic [ANGLE_WIDTH-1:0] QUAD_2 = 32'h8000_0000;
    localparam logic [ANGLE_WIDTH-1:0] QUAD_3 = 32'hC000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : cordic_phase_gen_pkg
`default_nettype wire

// File: rtl/cordic_phase_gen_valid_delay.sv
`default_nettype none
// ============================================================================
// Module      : valid_delay
// Description : 1-bit shift register delaying a valid strobe by DEPTH cycles,
//               used to align sample-valid with a fixed-latency pipeline.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset, clears the whole line
//               d     - strobe in
//               q     - strobe out, d delayed exactly DEPTH cycles
// Revision    : 1.0 - initial release
// ============================================================================
module valid_delay #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] r_line;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_line <= '0;
                else        r_line <= d;
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_line <= '0;
                else        r_line <= {r_line[DEPTH-2:0], d};
            end
        end
    endgenerate

    assign q = r_line[DEPTH-1];

endmodule : valid_delay
`default_nettype wire

// File: rtl/cordic_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : cordic_phase_gen
// Description : NCO / control stage in front of the pipelined CORDIC.
//               Phase accumulator produces the angle word each cycle; X_in is
//               the gain-compensated constant and Y_in is zero, so the CORDIC
//               emits full-scale cos/sin. Supports a fixed tone (RUN) and a
//               linear FCW sweep (SWEEP -> DONE -> RUN).
// Ports       : CLK, RST_N          - clock / async active-low reset
//               en                  - run enable
//               phase_clr           - synchronous accumulator clear
//               fcw_in, fcw_load    - frequency control word load
//               phase_ofs           - offset added to acc at the output
//               sweep_start/stop/step, sweep_go - chirp control
//               angle, X_in, Y_in   - CORDIC inputs
//               in_valid, out_valid - sample valid at CORDIC input / output
//               sweep_done, busy    - sweep status
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_phase_gen
    import cordic_phase_gen_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   en,
    input  logic                   phase_clr,
    input  logic [ANGLE_WIDTH-1:0] fcw_in,
    input  logic                   fcw_load,
    input  logic [ANGLE_WIDTH-1:0] phase_ofs,
    input  logic [ANGLE_WIDTH-1:0] sweep_start,
    input  logic [ANGLE_WIDTH-1:0] sweep_stop,
    input  logic [ANGLE_WIDTH-1:0] sweep_step,
    input  logic                   sweep_go,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic [XY_WIDTH-1:0]    X_in,
    output logic [XY_WIDTH-1:0]    Y_in,
    output logic                   in_valid,
    output logic                   out_valid,
    output logic                   sweep_done,
    output logic                   busy
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ANGLE_WIDTH-1:0] r_acc;
    logic [ANGLE_WIDTH-1:0] r_fcw_act;
    logic [ANGLE_WIDTH-1:0] r_angle;
    logic                   r_in_valid;

    logic                   w_active;
    logic                   w_go;
    logic                   w_load;
    logic [ANGLE_WIDTH-1:0] w_sweep_next;
    logic                   w_step_neg;
    logic                   w_sweep_hit;

    // A sample is produced only once the FSM has left IDLE and en is still
    // high; this gives the one-cycle start latency after en is first seen.
    assign w_active = en && (r_state != ST_IDLE);

    // sweep_go is honoured in IDLE/RUN/SWEEP (restart), never in DONE.
    assign w_go   = en && sweep_go && (r_state != ST_DONE);
    assign w_load = fcw_load && ((r_state == ST_IDLE) || (r_state == ST_RUN));

    assign w_sweep_next = r_fcw_act + sweep_step;
    assign w_step_neg   = sweep_step[ANGLE_WIDTH-1];
    assign w_sweep_hit  = (sweep_step == '0)
                        || (!w_step_neg && (w_sweep_next >= sweep_stop))
                        || ( w_step_neg && (w_sweep_next <= sweep_stop));

    // ---------------------------------------------------------------- state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) w_state_next = sweep_go ? ST_SWEEP : ST_RUN;
            end
            ST_RUN: begin
                if (!en)          w_state_next = ST_IDLE;
                else if (sweep_go) w_state_next = ST_SWEEP;
            end
            ST_SWEEP: begin
                if (!en)              w_state_next = ST_IDLE;
                else if (sweep_go)    w_state_next = ST_SWEEP;
                else if (w_sweep_hit) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = en ? ST_RUN : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy       = 1'b0;
        sweep_done = 1'b0;
        case (r_state)
            ST_SWEEP: busy       = 1'b1;
            ST_DONE:  sweep_done = 1'b1;
            default: begin
                busy       = 1'b0;
                sweep_done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_acc      <= QUAD_0;
            r_angle    <= QUAD_0;
            r_in_valid <= 1'b0;
        end else begin
            r_in_valid <= w_active;
            if (w_active) r_angle <= r_acc + phase_ofs;
            // Clear wins over accumulation; the sample above still used the
            // pre-clear accumulator.
            if (phase_clr)     r_acc <= '0;
            else if (w_active) r_acc <= r_acc + r_fcw_act;
        end
    end

    // FCW source priority: sweep_go > fcw_load > sweep step.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fcw_act <= '0;
        end else if (w_go) begin
            r_fcw_act <= sweep_start;
        end else if (w_load) begin
            r_fcw_act <= fcw_in;
        end else if ((r_state == ST_SWEEP) && en) begin
            r_fcw_act <= w_sweep_hit ? sweep_stop : w_sweep_next;
        end
    end

    valid_delay #(
        .DEPTH (STAGES)
    ) u_valid_delay (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (r_in_valid),
        .q     (out_valid)
    );

    assign angle    = r_angle;
    assign in_valid = r_in_valid;
    assign X_in     = GAIN_X;
    assign Y_in     = '0;

endmodule : cordic_phase_gen
`default_nettype wire

// File: tb/tb_cordic_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_phase_gen
// Description : Self-checking bench for cordic_phase_gen. A cycle model
//               predicts every output per clock; predictions are queued when
//               stimulus is applied and popped when the DUT settles. Directed
//               checks cover quadrant wrap, latency, sweeps, abort and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_phase_gen;
    import cordic_phase_gen_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        en, phase_clr, fcw_load, sweep_go;
    logic [31:0] fcw_in, phase_ofs, sweep_start, sweep_stop, sweep_step;
    logic [31:0] angle;
    logic [15:0] X_in, Y_in;
    logic        in_valid, out_valid, sweep_done, busy;

    cordic_phase_gen dut (
        .CLK(CLK), .RST_N(RST_N), .en(en), .phase_clr(phase_clr),
        .fcw_in(fcw_in), .fcw_load(fcw_load), .phase_ofs(phase_ofs),
        .sweep_start(sweep_start), .sweep_stop(sweep_stop),
        .sweep_step(sweep_step), .sweep_go(sweep_go),
        .angle(angle), .X_in(X_in), .Y_in(Y_in), .in_valid(in_valid),
        .out_valid(out_valid), .sweep_done(sweep_done), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- cycle model
    typedef struct packed {
        logic [31:0] angle;
        logic        iv, ov, busy, done;
    } exp_t;
    exp_t sb_q[$];

    int          m_st;      // 0 idle, 1 run, 2 sweep, 3 done
    logic [31:0] m_acc, m_fcw, m_angle;
    logic        m_iv;
    logic [15:0] m_line;

    task automatic model_reset();
        m_st = 0; m_acc = 0; m_fcw = 0; m_angle = 0; m_iv = 0; m_line = 0;
    endtask

    task automatic model_step();
        logic        act, hit;
        logic [31:0] nxt;
        int          st_n;
        exp_t        e;
        act = en && (m_st != 0);
        nxt = m_fcw + sweep_step;
        hit = (sweep_step == 0) || (!sweep_step[31] && nxt >= sweep_stop)
              || (sweep_step[31] && nxt <= sweep_stop);
        m_line = {m_line[14:0], m_iv};
        m_iv   = act;
        if (act) m_angle = m_acc + phase_ofs;
        if (phase_clr) m_acc = 0;
        else if (act)  m_acc = m_acc + m_fcw;
        if (en && sweep_go && m_st != 3)             m_fcw = sweep_start;
        else if (fcw_load && (m_st == 0 || m_st == 1)) m_fcw = fcw_in;
        else if (m_st == 2 && en)                    m_fcw = hit ? sweep_stop : nxt;
        st_n = m_st;
        if (!en && m_st != 0)          st_n = 0;
        else if (m_st == 0 && en)      st_n = sweep_go ? 2 : 1;
        else if (m_st == 1 && sweep_go) st_n = 2;
        else if (m_st == 2)            st_n = sweep_go ? 2 : (hit ? 3 : 2);
        else if (m_st == 3)            st_n = 1;
        m_st = st_n;
        e.angle = m_angle; e.iv = m_iv; e.ov = m_line[15];
        e.busy = (m_st == 2); e.done = (m_st == 3);
        sb_q.push_back(e);
    endtask

    // One clock: predict, clock, compare outputs against the prediction.
    task automatic tick();
        exp_t e;
        model_step();
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("angle",      angle,      e.angle);
            check("in_valid",   in_valid,   e.iv);
            check("out_valid",  out_valid,  e.ov);
            check("busy",       busy,       e.busy);
            check("sweep_done", sweep_done, e.done);
        end
    endtask

    int          lat, busy_cnt, done_cnt, ov_cnt, t_iv, t_ov;
    logic [31:0] prev_ang, delta;
    logic [31:0] quad_seq [5];

    // Run a sweep from a clean accumulator and check busy/done/final FCW.
    task automatic run_sweep(input string tag, input logic [31:0] s0, input logic [31:0] s1,
                             input logic [31:0] st, input int exp_busy, input logic [31:0] exp_fcw);
        sweep_start = s0; sweep_stop = s1; sweep_step = st; phase_ofs = 0;
        busy_cnt = 0; done_cnt = 0; prev_ang = 0; delta = 0;
        for (int i = 0; i < 12; i++) begin
            sweep_go = (i == 0); phase_clr = (i == 0);
            tick();
            if (busy) busy_cnt++;
            if (sweep_done) done_cnt++;
            delta = angle - prev_ang; prev_ang = angle;
        end
        sweep_go = 0; phase_clr = 0;
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_final_fcw"},   delta,    exp_fcw);
    endtask

    initial begin
        quad_seq[0] = QUAD_0; quad_seq[1] = QUAD_1; quad_seq[2] = QUAD_2;
        quad_seq[3] = QUAD_3; quad_seq[4] = QUAD_0;
        RST_N = 0; en = 0; phase_clr = 0; fcw_load = 0; sweep_go = 0;
        fcw_in = 0; phase_ofs = 0; sweep_start = 0; sweep_stop = 0; sweep_step = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_angle", angle, 0);
        check("rst_in_valid", in_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("X_in_const", X_in, 16'd19898);
        check("Y_in_const", Y_in, 0);
        @(negedge CLK);
        RST_N = 1;

        // Quarter-turn tone: quadrant sequence with wrap, start latency.
        fcw_in = QUAD_1; fcw_load = 1; en = 1;
        tick();
        fcw_load = 0;
        check("iv_after_en_edge", in_valid, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("quad_angle", angle, quad_seq[i]);
        end
        lat = 4;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check("ov_latency", lat, STAGES);

        // Clear + load on one edge, constant offset tone.
        fcw_in = 0; fcw_load = 1; phase_clr = 1; phase_ofs = 32'h2000_0000;
        tick();
        fcw_load = 0; phase_clr = 0;
        tick();
        check("ofs_first", angle, 32'h2000_0000);
        repeat (3) tick();
        check("ofs_const", angle, 32'h2000_0000);

        // Chirps: up, down, zero step.
        run_sweep("up",   32'd100, 32'd300, 32'd50,           4, 32'd300);
        run_sweep("down", 32'd300, 32'd100, 32'hFFFF_FFCE,    4, 32'd100);
        run_sweep("zero", 32'd100, 32'd300, 32'd0,            1, 32'd300);

        // Abort mid-sweep: no done, pipeline drains.
        sweep_start = 0; sweep_stop = 32'hFFFF_FFF0; sweep_step = 1; sweep_go = 1;
        tick();
        sweep_go = 0;
        repeat (3) tick();
        en = 0;
        ov_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 0) check("abort_iv", in_valid, 0);
            if (out_valid) ov_cnt++;
            if (sweep_done) done_cnt++;
        end
        check("abort_drain", ov_cnt, 16);
        check("abort_no_done", done_cnt, 0);

        // Random mixed traffic, fully covered by the model.
        for (int i = 0; i < 80; i++) begin
            en          = ($urandom_range(0, 9) != 0);
            phase_clr   = ($urandom_range(0, 7) == 0);
            fcw_load    = ($urandom_range(0, 3) == 0);
            fcw_in      = $urandom;
            phase_ofs   = $urandom;
            sweep_go    = ($urandom_range(0, 15) == 0);
            sweep_start = $urandom_range(0, 1000);
            sweep_stop  = $urandom_range(0, 1000);
            sweep_step  = $urandom_range(0, 1) ? 32'd37 : 32'hFFFF_FFDB;
            tick();
        end
        phase_clr = 0; fcw_load = 0; sweep_go = 0;

        // Asynchronous reset in the middle of a run.
        en = 1; fcw_in = 32'h0123_4567; fcw_load = 1;
        tick();
        fcw_load = 0;
        repeat (20) tick();
        #2;
        RST_N = 0;
        #1;
        check("arst_angle", angle, 0);
        check("arst_in_valid", in_valid, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        model_reset();
        sb_q.delete();
        @(negedge CLK);
        RST_N = 1;
        t_iv = -1; t_ov = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (in_valid && t_iv < 0) t_iv = i;
            if (out_valid && t_ov < 0) t_ov = i;
        end
        check("arst_relatency", t_ov - t_iv, STAGES);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_cordic_phase_gen
`default_nettype wire
